// File: rtl/xor_nn_pkg.sv
// Shared constants and types for the XOR network output layer.
// Q4.4 fixed point throughout: W=8 total bits, FRAC=4 fractional bits.
package xor_nn_pkg;

    localparam int W     = 8;
    localparam int FRAC  = 4;
    localparam int N_IN  = 2;
    localparam int ACC_W = 16;
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    // Output-layer weights, indexed by hidden activation number
    localparam logic signed [W-1:0] OUT_W [N_IN] = '{8'sd20, -8'sd22};

    // Output-layer bias
    localparam logic signed [W-1:0] OUT_B = -8'sd3;

    // Saturation limits for the accumulator-to-W narrowing
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (W - 1)));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC  = 3'd1,
        S_BIAS = 3'd2,
        S_ACT  = 3'd3,
        S_DONE = 3'd4
    } out_state_t;

endpackage

// File: rtl/xor_output_layer_act.sv
// Combinational narrow + hard-sigmoid for the output neuron.
// Build option: OUT_LAYER_SAT_EN selects saturating narrowing of the
// accumulator; when undefined the low W bits are kept (two's-complement wrap),
// matching the hidden-layer arithmetic.
module out_layer_act
    import xor_nn_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [W-1:0]     o_y
);

    localparam logic signed [W+1:0] ACT_OFS = (W + 2)'(8);
    localparam logic signed [W+1:0] ACT_TOP = (W + 2)'(16);

    logic signed [W-1:0] w_z;
    logic signed [W+1:0] w_zx;
    logic signed [W+1:0] w_sum;

    // Narrow the accumulator to W bits, then y = clamp((z >>> 2) + 8, 0, 16)
    always_comb begin
        w_z   = W'(i_acc);
`ifdef OUT_LAYER_SAT_EN
        if (i_acc > SAT_HI) begin
            w_z = W'(SAT_HI);
        end else if (i_acc < SAT_LO) begin
            w_z = W'(SAT_LO);
        end else begin
            w_z = W'(i_acc);
        end
`endif
        // Sign-extend before the shift so the floor shift stays arithmetic
        w_zx  = {{2{w_z[W-1]}}, w_z};
        w_sum = (w_zx >>> 2) + ACT_OFS;
        if (w_sum < (W + 2)'(0)) begin
            o_y = '0;
        end else if (w_sum > ACT_TOP) begin
            o_y = W'(ACT_TOP);
        end else begin
            o_y = W'(w_sum);
        end
    end

endmodule

// File: rtl/xor_output_layer.sv
// XOR network output neuron: latches hidden activations on req, runs a
// one-term-per-cycle MAC against the weight ROM, adds the bias and applies
// the hard sigmoid, then answers over a 4-phase req/ack handshake.
// Build option: OUT_LAYER_SAT_EN (see out_layer_act) changes only the
// narrowing arithmetic; timing is identical in both builds.
module xor_output_layer
    import xor_nn_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [N_IN*W-1:0]      a_in,
    output logic                   ack,
    output logic signed [W-1:0]    y,
    output logic                   busy
);

    out_state_t                r_state;
    logic signed [W-1:0]       r_a [N_IN];
    logic signed [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_ack;
    logic signed [W-1:0]       r_y;
    logic                      r_busy;

    logic signed [2*W-1:0]     w_a_ext;
    logic signed [2*W-1:0]     w_w_ext;
    logic signed [2*W-1:0]     w_prod;
    logic signed [ACC_W-1:0]   w_term;
    logic signed [ACC_W-1:0]   w_bias;
    logic signed [W-1:0]       w_y;
    logic signed [W-1:0]       w_a_sel;
    logic signed [W-1:0]       w_w_sel;

    // Current MAC term: full-width signed product, floor-shifted back to Q4.4
    always_comb begin
        w_a_sel = r_a[r_idx];
        w_w_sel = OUT_W[r_idx];
        w_a_ext = {{W{w_a_sel[W-1]}}, w_a_sel};
        w_w_ext = {{W{w_w_sel[W-1]}}, w_w_sel};
        w_prod  = w_a_ext * w_w_ext;
        w_term  = ACC_W'(w_prod >>> FRAC);
        w_bias  = {{(ACC_W - W){OUT_B[W-1]}}, OUT_B};
    end

    out_layer_act u_act (
        .i_acc (r_acc),
        .o_y   (w_y)
    );

    // Handshake FSM with activation latch, accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
            r_ack   <= 1'b0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                r_a[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        for (int i = 0; i < N_IN; i++) begin
                            r_a[i] <= a_in[i*W +: W];
                        end
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(N_IN - 1)) begin
                        r_state <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    r_acc   <= r_acc + w_bias;
                    r_state <= S_ACT;
                end
                S_ACT: begin
                    r_y     <= w_y;
                    r_ack   <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!req) begin
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack  = r_ack;
    assign y    = r_y;
    assign busy = r_busy;

endmodule

// File: tb/tb_xor_output_layer.sv
// Directed self-checking bench for xor_output_layer.
module tb_xor_output_layer;
    import xor_nn_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                req;
    logic [N_IN*W-1:0]   a_in;
    logic                ack;
    logic signed [W-1:0] y;
    logic                busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xor_output_layer dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a_in (a_in),
        .ack  (ack),
        .y    (y),
        .busy (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until ack rises or the budget runs out; n = edges taken
    task automatic wait_ack(output int n);
        n = 0;
        while (ack !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; a_in = '0;
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if (ack !== 1'b0 || y !== 8'sd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: ack=%b y=%0d busy=%b, required ack=0 y=0 busy=0", ack, y, busy);
        end
    endtask

    task automatic test_truth_table();
        logic [W-1:0] tv_a0 [4];
        logic [W-1:0] tv_a1 [4];
        logic [W-1:0] tv_y  [4];
        int n;
        tv_a0 = '{8'd16, 8'd16, 8'd0,  8'd0};
        tv_a1 = '{8'd16, 8'd0,  8'd16, 8'd0};
        tv_y  = '{8'd6,  8'd12, 8'd1,  8'd7};
        for (int k = 0; k < 4; k++) begin
            a_in = {tv_a1[k], tv_a0[k]};
            req  = 1'b1;
            wait_ack(n);
            checks++;
            if (n != 5) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d edges, required 5", k, n);
            end
            checks++;
            if (y !== tv_y[k]) begin
                errors++;
                $display("FAIL y[%0d]: got %0d, required %0d", k, y, tv_y[k]);
            end
            req = 1'b0;
            step();
            checks++;
            if (ack !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL release[%0d]: ack=%b busy=%b, required 0 0", k, ack, busy);
            end
        end
    endtask

    task automatic test_narrow();
        int n;
        logic [W-1:0] exp_y;
`ifdef OUT_LAYER_SAT_EN
        exp_y = 8'd16;
`else
        exp_y = 8'd0;
`endif
        a_in = {8'd0, 8'd127};
        req  = 1'b1;
        wait_ack(n);
        checks++;
        if (n != 5 || y !== exp_y) begin
            errors++;
            $display("FAIL narrow: edges=%0d y=%0d, required edges=5 y=%0d", n, y, exp_y);
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_hold();
        int n;
        int bad;
        a_in = {8'd16, 8'd16};
        req  = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: got %b, required 1", busy);
        end
        wait_ack(n);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (ack !== 1'b1 || y !== 8'sd6 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold: %0d bad cycles (last ack=%b y=%0d busy=%b), required 0", bad, ack, y, busy);
        end
        req = 1'b0;
        step();
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: ack=%b busy=%b, required 0 0", ack, busy);
        end
    endtask

    task automatic test_short_req();
        int n;
        a_in = {8'd0, 8'd16};
        req  = 1'b1;
        step();
        req  = 1'b0;
        wait_ack(n);
        checks++;
        if (n != 4 || y !== 8'sd12) begin
            errors++;
            $display("FAIL short_req: edges=%0d y=%0d, required edges=4 y=12", n, y);
        end
        step();
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse: ack=%b after one cycle, required 0", ack);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        a_in = {8'd16, 8'd16};
        req  = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 1'b0;
        checks++;
        if (ack !== 1'b0 || y !== 8'sd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: ack=%b y=%0d busy=%b, required 0 0 0", ack, y, busy);
        end
        step();
        req = 1'b1;
        wait_ack(n);
        checks++;
        if (n != 5 || y !== 8'sd6) begin
            errors++;
            $display("FAIL rst_restart: edges=%0d y=%0d, required edges=5 y=6", n, y);
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_latch();
        int n;
        a_in = {8'd0, 8'd16};
        req  = 1'b1;
        step();
        step();
        a_in = {8'd16, 8'd0};
        wait_ack(n);
        checks++;
        if (n != 3 || y !== 8'sd12) begin
            errors++;
            $display("FAIL latch: edges=%0d y=%0d, required edges=3 y=12", n, y);
        end
        req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_narrow();
        test_hold();
        test_short_req();
        test_rst_mid();
        test_latch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xor_output_layer.md
# xor_output_layer

Output-layer neuron of the XOR network, sitting directly downstream of the hidden layer. It consumes the N_IN hidden activations once the hidden layer acknowledges. It multiply-accumulates them against a fixed weight ROM in Q4.4 fixed point, adds the output bias, and applies a hard-sigmoid activation. It returns the final network output over a 4-phase req/ack handshake.

## Interface
- N_IN, 2, number of hidden activations consumed (1..16)
- W, 8, data width of activations, weights, bias and output (signed, Q4.4)
- FRAC, 4, fractional bits; product rescale shift
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  request; driven by hidden-layer ack, level, held until ack seen
- a_in  in  N_IN*W  packed signed activations; element i at bits [i*W +: W]
- ack  out  1  result valid; reset 0
- y  out  W  signed network output, range 0..16 (0.0..1.0); reset 0
- busy  out  1  high in any state other than IDLE; reset 0

## Operation
- FSM states: IDLE, MAC, BIAS, ACT, DONE.
- IDLE: on req=1, latch all of a_in, clear acc, set idx=0, go to MAC. The a_in bus is not sampled again until the next IDLE request.
- MAC: one term per cycle. acc += (a[idx]*OUT_W[idx]) >>> FRAC, using a signed 2W-bit product and an arithmetic (floor) shift.
  - idx increments each cycle.
  - At idx==N_IN-1, go to BIAS.
- BIAS: acc += OUT_B; go to ACT.
- ACT: z = narrow(acc) to W bits (see Configuration). y <= clamp((z >>> 2) + 8, 0, 16). ack <= 1. Go to DONE.
- DONE: hold y and ack. When req==0, ack <= 0 and go to IDLE.
- Accumulator: signed 16 bits. No internal overflow is possible for N_IN ≤ 16.
- Weights are read from the ROM by idx. The bias is a constant.

## Timing
- Request to ack latency: N_IN+3 rising edges, counting the edge that samples req in IDLE. With N_IN=2, ack goes high 5 cycles after req is sampled.
- y changes only on the ACT edge. It is stable for the whole time ack=1.
- ack falls on the first edge in DONE with req=0. IDLE is entered on that same edge. The earliest restart is the next edge.
- req is high continuously in DONE: no retrigger, ack stays 1.
- req falls before ack: the computation completes anyway. ack pulses high for exactly 1 cycle in DONE, then clears.
- a_in changing during MAC/BIAS/ACT: ignored, because of the latched copy.
- rst mid-operation: on the next edge the state is IDLE, acc=0, idx=0, ack=0, y=0, busy=0. rst overrides req on the same edge.

## Configuration
- OUT_LAYER_SAT_EN defined: narrow() saturates acc to [-2^(W-1), 2^(W-1)-1] before activation.
- OUT_LAYER_SAT_EN undefined: narrow() truncates to the low W bits (two's-complement wrap), matching the hidden-layer arithmetic.
- Both builds are otherwise cycle-identical.

## Structure
- Package xor_nn_pkg:
  - constants W=8, FRAC=4, N_IN=2
  - weight array OUT_W = {20, -22} (index 0, 1)
  - OUT_B = -3
  - state enum typedef for IDLE/MAC/BIAS/ACT/DONE
- Sub-module out_layer_act: combinational narrow + hard-sigmoid (z → y), with OUT_LAYER_SAT_EN visible inside it. The top holds the FSM, latch, accumulator and weight ROM.

## Test plan
- Each case pulses req, checks ack after 5 cycles, then drops req:
  - a=(16,16) → y=6
  - a=(16,0) → y=12
  - a=(0,16) → y=1
  - a=(0,0) → y=7
- a=(127,0) → acc=155. With OUT_LAYER_SAT_EN: y=16. Without it: y=0.
- Hold req high for 10 cycles after ack → ack stays 1, y constant, busy=1, no second computation. Drop req → ack=0 the next edge.
- Raise req for 1 cycle only with a=(16,0) → ack high for exactly 1 cycle at cycle 5, y=12.
- Assert rst during MAC, then release → ack=0, y=0, busy=0. A new req with a=(16,16) gives y=6 at the normal latency.
- Change a_in to (0,16) 2 cycles after req with original a=(16,0) → y=12 (latched values used).
